// File: rtl/arb_pkg.sv
// Shared types and constants for the sequential square arbiter (arb_seq).
// State encodings are plain localparams; the enum mirrors them for debug visibility.
package arb_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_OUT  = 2'd2;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_SCAN = 2'd1,
    ARB_OUT  = 2'd2
  } arb_state_e;

  // Index width for n items, never below one bit.
  function automatic int arb_idx_w(input int n);
    if (n <= 2) return 1;
    return $clog2(n);
  endfunction

  localparam int ARB_DEF_NUM_SQ = 64;
  localparam int ARB_EMPTY_BIT  = arb_idx_w(ARB_DEF_NUM_SQ);
  localparam logic [ARB_EMPTY_BIT:0] ARB_EMPTY = {1'b1, {ARB_EMPTY_BIT{1'b0}}};

endpackage

// File: rtl/arb_chunk_max.sv
// Combinational LANES-input max-with-index reducer built as a binary tree of arb_unit.
// Lowest index wins ties because every left subtree covers lower lanes.
module arb_chunk_max #(
  parameter int PRIO_W = 3,
  parameter int IDX_W  = 6,
  parameter int LANES  = 8
) (
  input  logic [LANES*PRIO_W-1:0] prio_i,
  input  logic [IDX_W-1:0]        base_i,
  output logic [PRIO_W-1:0]       prio_o,
  output logic [IDX_W-1:0]        idx_o
);

  localparam int NODES = 2 * LANES - 1;

  // Heap layout: node n has children 2n+1 (left) and 2n+2; leaves start at LANES-1.
  logic [PRIO_W-1:0] node_prio [NODES];
  logic [IDX_W-1:0]  node_idx  [NODES];

  for (genvar j = 0; j < LANES; j++) begin : g_leaf
    assign node_prio[LANES-1+j] = prio_i[j*PRIO_W +: PRIO_W];
    assign node_idx[LANES-1+j]  = base_i + IDX_W'(j);
  end

  for (genvar n = 0; n < LANES - 1; n++) begin : g_node
    arb_unit #(
      .PRIO_W (PRIO_W),
      .IDX_W  (IDX_W)
    ) u_unit (
      .a_prio_i (node_prio[2*n+1]),
      .a_idx_i  (node_idx[2*n+1]),
      .b_prio_i (node_prio[2*n+2]),
      .b_idx_i  (node_idx[2*n+2]),
      .prio_o   (node_prio[n]),
      .idx_o    (node_idx[n])
    );
  end

  assign prio_o = node_prio[0];
  assign idx_o  = node_idx[0];

endmodule

// File: rtl/arb_unit.sv
// Two-way priority comparator; side a is the lower index and wins ties.
module arb_unit #(
  parameter int PRIO_W = 3,
  parameter int IDX_W  = 6
) (
  input  logic [PRIO_W-1:0] a_prio_i,
  input  logic [IDX_W-1:0]  a_idx_i,
  input  logic [PRIO_W-1:0] b_prio_i,
  input  logic [IDX_W-1:0]  b_idx_i,
  output logic [PRIO_W-1:0] prio_o,
  output logic [IDX_W-1:0]  idx_o
);

  logic take_b;

  assign take_b = (b_prio_i > a_prio_i);
  assign prio_o = take_b ? b_prio_i : a_prio_i;
  assign idx_o  = take_b ? b_idx_i  : a_idx_i;

endmodule

// File: rtl/arb_seq.sv
// Sequential square arbiter: scans LANES squares per cycle and streams squares in priority order.
// Optional ARB_SEQ_EARLY_EXIT_EN ends a scan as soon as the best priority is all-ones.
module arb_seq
  import arb_pkg::*;
#(
  parameter int NUM_SQ = 64,
  parameter int PRIO_W = 3,
  parameter int LANES  = 8,
  localparam int IDX_W = arb_idx_w(NUM_SQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [NUM_SQ*PRIO_W-1:0] priority_,
  output logic                     busy,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [IDX_W:0]           data_out,
  output arb_state_e               dbg_state_o
);

  // Handshake: data_out is held while out_valid is high; a result transfers on a
  // rising edge where out_valid && out_ready. out_ready is ignored otherwise.

  localparam int NCHUNK  = NUM_SQ / LANES;
  localparam int CNT_W   = arb_idx_w(NCHUNK);
  localparam int SLICE_W = LANES * PRIO_W;
  localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(NCHUNK - 1);
  localparam logic [IDX_W:0]   EMPTY_RES  = {1'b1, {IDX_W{1'b0}}};

  logic [1:0]               state_q, state_d;
  logic [NUM_SQ*PRIO_W-1:0] prio_q, prio_d;
  logic [CNT_W-1:0]         chunk_q, chunk_d;
  logic [PRIO_W-1:0]        best_prio_q, best_prio_d;
  logic [IDX_W-1:0]         best_idx_q, best_idx_d;
  logic [IDX_W:0]           data_q, data_d;
  logic                     valid_q, valid_d;

  logic [SLICE_W-1:0] chunk_prio;
  logic [IDX_W-1:0]   chunk_base;
  logic [PRIO_W-1:0]  cand_prio, merge_prio;
  logic [IDX_W-1:0]   cand_idx, merge_idx;
  logic               scan_done;

  assign chunk_prio = prio_q[int'(chunk_q)*SLICE_W +: SLICE_W];
  assign chunk_base = IDX_W'(int'(chunk_q) * LANES);

  arb_chunk_max #(
    .PRIO_W (PRIO_W),
    .IDX_W  (IDX_W),
    .LANES  (LANES)
  ) u_chunk (
    .prio_i (chunk_prio),
    .base_i (chunk_base),
    .prio_o (cand_prio),
    .idx_o  (cand_idx)
  );

  // Best so far always comes from lower indices, so it sits on the tie-winning side.
  arb_unit #(
    .PRIO_W (PRIO_W),
    .IDX_W  (IDX_W)
  ) u_merge (
    .a_prio_i (best_prio_q),
    .a_idx_i  (best_idx_q),
    .b_prio_i (cand_prio),
    .b_idx_i  (cand_idx),
    .prio_o   (merge_prio),
    .idx_o    (merge_idx)
  );

`ifdef ARB_SEQ_EARLY_EXIT_EN
  assign scan_done = (chunk_q == LAST_CHUNK) || (&merge_prio);
`else
  assign scan_done = (chunk_q == LAST_CHUNK);
`endif

  always_comb begin
    state_d     = state_q;
    prio_d      = prio_q;
    chunk_d     = chunk_q;
    best_prio_d = best_prio_q;
    best_idx_d  = best_idx_q;
    data_d      = data_q;
    valid_d     = valid_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          prio_d      = priority_;
          chunk_d     = '0;
          best_prio_d = '0;
          best_idx_d  = '0;
          state_d     = ST_SCAN;
        end
      end
      ST_SCAN: begin
        best_prio_d = merge_prio;
        best_idx_d  = merge_idx;
        if (scan_done) begin
          data_d  = (merge_prio == '0) ? EMPTY_RES : {1'b0, merge_idx};
          valid_d = 1'b1;
          state_d = ST_OUT;
        end else begin
          chunk_d = chunk_q + 1'b1;
        end
      end
      ST_OUT: begin
        if (out_ready) begin
          valid_d = 1'b0;
          if (data_q[IDX_W]) begin
            state_d = ST_IDLE;
          end else begin
            // Mask the square just emitted so the rescan finds the next one.
            for (int i = 0; i < NUM_SQ; i++) begin
              if (IDX_W'(i) == data_q[IDX_W-1:0]) prio_d[i*PRIO_W +: PRIO_W] = '0;
            end
            chunk_d     = '0;
            best_prio_d = '0;
            best_idx_d  = '0;
            state_d     = ST_SCAN;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      prio_q      <= '0;
      chunk_q     <= '0;
      best_prio_q <= '0;
      best_idx_q  <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      prio_q      <= prio_d;
      chunk_q     <= chunk_d;
      best_prio_q <= best_prio_d;
      best_idx_q  <= best_idx_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
    end
  end

  assign busy        = (state_q != ST_IDLE);
  assign out_valid   = valid_q;
  assign data_out    = data_q;
  assign dbg_state_o = arb_state_e'(state_q);

endmodule

// File: tb/tb_arb_seq.sv
// Directed bench for arb_seq: three instances (LANES 8, 1, 64) share stimulus, selected by sel.
module tb_arb_seq;
  import arb_pkg::*;

  localparam int NUM_SQ = 64;
  localparam int PRIO_W = 3;
  localparam int IDX_W  = 6;
  localparam int PW     = NUM_SQ * PRIO_W;
  localparam logic [IDX_W:0] EMPTY = 7'h40;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          start_r = 1'b0;
  logic          ready_r = 1'b0;
  logic [PW-1:0] prio_r  = '0;
  int            sel     = 0;

  logic [2:0]     start_v, ready_v, busy_v, valid_v;
  logic [IDX_W:0] data_v [3];
  arb_state_e     state_v [3];

  always_comb begin
    for (int k = 0; k < 3; k++) begin
      start_v[k] = start_r && (sel == k);
      ready_v[k] = ready_r && (sel == k);
    end
  end

  logic           valid_m, busy_m;
  logic [IDX_W:0] data_m;
  arb_state_e     state_m;
  assign valid_m = valid_v[sel];
  assign busy_m  = busy_v[sel];
  assign data_m  = data_v[sel];
  assign state_m = state_v[sel];

  arb_seq #(.NUM_SQ(NUM_SQ), .PRIO_W(PRIO_W), .LANES(8)) u_l8 (
    .clk(clk), .rst(rst), .start(start_v[0]), .priority_(prio_r), .busy(busy_v[0]),
    .out_valid(valid_v[0]), .out_ready(ready_v[0]), .data_out(data_v[0]), .dbg_state_o(state_v[0])
  );
  arb_seq #(.NUM_SQ(NUM_SQ), .PRIO_W(PRIO_W), .LANES(1)) u_l1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .priority_(prio_r), .busy(busy_v[1]),
    .out_valid(valid_v[1]), .out_ready(ready_v[1]), .data_out(data_v[1]), .dbg_state_o(state_v[1])
  );
  arb_seq #(.NUM_SQ(NUM_SQ), .PRIO_W(PRIO_W), .LANES(64)) u_l64 (
    .clk(clk), .rst(rst), .start(start_v[2]), .priority_(prio_r), .busy(busy_v[2]),
    .out_valid(valid_v[2]), .out_ready(ready_v[2]), .data_out(data_v[2]), .dbg_state_o(state_v[2])
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [IDX_W:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts edges from the one that sampled the trigger (counted as 1) until out_valid.
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!valid_m && lat < 200) begin
      tick();
      lat++;
    end
  endtask

  task automatic do_start(output int lat);
    start_r = 1'b1;
    tick();
    start_r = 1'b0;
    wait_valid(lat);
  endtask

  task automatic accept();
    ready_r = 1'b1;
    tick();
    ready_r = 1'b0;
  endtask

  task automatic set_sq(input int sq, input int p);
    prio_r[sq*PRIO_W +: PRIO_W] = PRIO_W'(p);
  endtask

  // Reference order: priority descending, index ascending, then the empty terminator.
  task automatic build_model();
    exp_q.delete();
    for (int p = 7; p >= 1; p--)
      for (int i = 0; i < NUM_SQ; i++)
        if (prio_r[i*PRIO_W +: PRIO_W] == PRIO_W'(p)) exp_q.push_back({1'b0, IDX_W'(i)});
    exp_q.push_back(EMPTY);
  endtask

  task automatic run_stream(input string tag, input int exp_lat);
    logic [IDX_W:0] e;
    int lat;
    do_start(lat);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_eq({tag, "_lat"}, lat, exp_lat);
      check_eq({tag, "_data"}, data_m, e);
      accept();
      if (exp_q.size() > 0) wait_valid(lat);
    end
    check_eq({tag, "_busy_end"}, busy_m, 1'b0);
  endtask

  // ---------------- tests ----------------
  initial begin
    int lat;
    int lat_exp [3];
    lat_exp[0] = 9;
    lat_exp[1] = 65;
    lat_exp[2] = 2;

    #2;
    check_eq("rst_valid", valid_m, 1'b0);
    check_eq("rst_busy", busy_m, 1'b0);
    check_eq("rst_data", data_m, 0);
    check_eq("rst_state", state_m, ARB_IDLE);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // 1: single candidate, sq 37 = 5
    sel = 0;
    prio_r = '0;
    set_sq(37, 5);
    do_start(lat);
    check_eq("t1_lat", lat, 9);
    check_eq("t1_data", data_m, 7'h25);
    check_eq("t1_busy", busy_m, 1'b1);
    accept();
    wait_valid(lat);
    check_eq("t1_lat2", lat, 9);
    check_eq("t1_empty", data_m, 7'h40);
    accept();
    check_eq("t1_idle_busy", busy_m, 1'b0);
    check_eq("t1_idle_valid", valid_m, 1'b0);
    check_eq("t1_idle_state", state_m, ARB_IDLE);

    // 2: ties resolved to lowest index
    prio_r = '0;
    set_sq(10, 6);
    set_sq(3, 6);
    set_sq(50, 6);
    set_sq(0, 2);
    exp_q = '{7'h03, 7'h0A, 7'h32, 7'h00, 7'h40};
    run_stream("t2", 9);

    // 3: backpressure, with start pulses and a changed input vector during the stall
    prio_r = '0;
    set_sq(37, 5);
    set_sq(12, 3);
    do_start(lat);
    check_eq("t3_first", data_m, 7'h25);
    for (int c = 0; c < 20; c++) begin
      start_r = (c % 3 == 0);
      if (c == 5) prio_r = ~prio_r;
      tick();
      check_eq("t3_stall_valid", valid_m, 1'b1);
      check_eq("t3_stall_data", data_m, 7'h25);
    end
    start_r = 1'b0;
    accept();
    wait_valid(lat);
    check_eq("t3_second", data_m, 7'h0C);
    check_eq("t3_second_lat", lat, 9);
    accept();
    wait_valid(lat);
    check_eq("t3_empty", data_m, 7'h40);
    accept();
    check_eq("t3_idle", busy_m, 1'b0);

    // 4: asynchronous reset in the middle of a scan
    prio_r = '0;
    set_sq(20, 4);
    start_r = 1'b1;
    tick();
    start_r = 1'b0;
    ready_r = 1'b1;
    tick();
    tick();
    tick();
    ready_r = 1'b0;
    check_eq("t4_scanning", state_m, ARB_SCAN);
    #2 rst = 1'b1;
    #1;
    check_eq("t4_rst_valid", valid_m, 1'b0);
    check_eq("t4_rst_busy", busy_m, 1'b0);
    check_eq("t4_rst_data", data_m, 0);
    @(negedge clk);
    rst = 1'b0;
    set_sq(55, 3);
    exp_q = '{7'h14, 7'h37, 7'h40};
    run_stream("t4_fresh", 9);

    // 6: all-ones priority at sq 2
    prio_r = '0;
    set_sq(2, 7);
    do_start(lat);
`ifdef ARB_SEQ_EARLY_EXIT_EN
    check_eq("t6_lat", lat, 2);
`else
    check_eq("t6_lat", lat, 9);
`endif
    check_eq("t6_data", data_m, 7'h02);
    accept();
    wait_valid(lat);
    check_eq("t6_empty_lat", lat, 9);
    check_eq("t6_empty", data_m, 7'h40);
    accept();

    // 5: lane sweep against the sorted reference (no all-ones priorities, so latency is fixed)
    for (int k = 0; k < 3; k++) begin
      sel = k;
      for (int i = 0; i < NUM_SQ; i++) set_sq(i, (i * 5 + 3 + k) % 7);
      build_model();
      run_stream($sformatf("t5_l%0d", k), lat_exp[k]);
    end
    sel = 0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
